// File: rtl/axis_rx_multilane.sv
// axis_rx_multilane: oversampling multi-lane serial receiver feeding a FWFT FIFO and an AXI4-Stream master.
// Define AXIS_RX_OVF_CNT_EN to add the ovf_count port and its 16-bit saturating drop counter.
//
// state | meaning
// IDLE  | no packet in progress; waits for a sample event with svalid=1
// SHIFT | packet in progress; shifts one beat per sample event
module axis_rx_multilane #(
  parameter int PACKET_LENGTH  = 32,
  parameter int NUM_LANES      = 1,
  parameter int PKTS_PER_FRAME = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     enable,
  input  logic                     sclk,
  input  logic [NUM_LANES-1:0]     sdata,
  input  logic                     svalid,
  output logic [PACKET_LENGTH-1:0] m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tuser,
`ifdef AXIS_RX_OVF_CNT_EN
  output logic [15:0]              ovf_count,
`endif
  output logic                     overflow
);

  localparam int BEATS = PACKET_LENGTH / NUM_LANES;
  localparam int CW    = $clog2(BEATS + 1);
  localparam int FW    = (PKTS_PER_FRAME > 1) ? $clog2(PKTS_PER_FRAME) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EW    = PACKET_LENGTH + 2;

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, svalid_sync;
  logic [NUM_LANES-1:0]   sdata_sync [SYNC_STAGES];
  logic                   sclk_prev;
  logic                   sample, s_valid;
  logic [NUM_LANES-1:0]   s_data;

  always_ff @(posedge aclk) begin
    if (areset) begin
      sclk_sync   <= '0;
      svalid_sync <= '0;
      sclk_prev   <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sdata_sync[i] <= '0;
    end else begin
      sclk_sync     <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      svalid_sync   <= {svalid_sync[SYNC_STAGES-2:0], svalid};
      sdata_sync[0] <= sdata;
      for (int i = 1; i < SYNC_STAGES; i++) sdata_sync[i] <= sdata_sync[i-1];
      sclk_prev     <= sclk_sync[SYNC_STAGES-1];
    end
  end

  // Data and qualifier come from the same final stage as the falling sclk edge.
  assign sample  = sclk_prev & ~sclk_sync[SYNC_STAGES-1];
  assign s_data  = sdata_sync[SYNC_STAGES-1];
  assign s_valid = svalid_sync[SYNC_STAGES-1];

  state_t                   state, state_nxt;
  logic [PACKET_LENGTH-1:0] shift_reg, shift_nxt, beat_word, data_nxt;
  logic [CW-1:0]            beat_cnt, cnt_nxt;
  logic                     push_nxt, user_nxt;
  logic [FW-1:0]            frame_cnt;
  logic                     frame_last;
  logic                     push_vld;
  logic [EW-1:0]            push_word;

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    cnt_nxt   = beat_cnt;
    push_nxt  = 1'b0;
    user_nxt  = 1'b0;
    data_nxt  = shift_reg;
    beat_word = (shift_reg << NUM_LANES) | PACKET_LENGTH'(s_data);
    if (!enable) begin
      state_nxt = IDLE;
      shift_nxt = '0;
      cnt_nxt   = '0;
    end else if (sample) begin
      unique case (state)
        IDLE: begin
          if (s_valid) begin
            shift_nxt = PACKET_LENGTH'(s_data);
            if (BEATS == 1) begin
              push_nxt = 1'b1;
              data_nxt = PACKET_LENGTH'(s_data);
              cnt_nxt  = '0;
            end else begin
              cnt_nxt   = CW'(1);
              state_nxt = SHIFT;
            end
          end
        end
        SHIFT: begin
          if (s_valid) begin
            shift_nxt = beat_word;
            data_nxt  = beat_word;
            if (beat_cnt == CW'(BEATS - 1)) begin
              push_nxt  = 1'b1;
              cnt_nxt   = '0;
              state_nxt = IDLE;
            end else begin
              cnt_nxt = beat_cnt + 1'b1;
            end
          end else begin
            // Truncated packet: shift_reg is already right-aligned with zero upper bits.
            push_nxt  = 1'b1;
            user_nxt  = 1'b1;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end
      endcase
    end
  end

  assign frame_last = (frame_cnt == FW'(PKTS_PER_FRAME - 1));

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      shift_reg <= '0;
      beat_cnt  <= '0;
      frame_cnt <= '0;
      push_vld  <= 1'b0;
      push_word <= '0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      beat_cnt  <= cnt_nxt;
      push_vld  <= push_nxt;
      if (push_nxt) begin
        push_word <= {data_nxt, user_nxt, frame_last};
        frame_cnt <= frame_last ? '0 : frame_cnt + 1'b1;
      end
    end
  end

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full, pop, push_ok;
  logic [EW-1:0] head;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = m_axis_tvalid & m_axis_tready;
  assign push_ok    = push_vld & (~fifo_full | pop);

  always_ff @(posedge aclk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_word;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_vld && !push_ok) overflow <= 1'b1;
    end
  end

`ifdef AXIS_RX_OVF_CNT_EN
  always_ff @(posedge aclk) begin
    if (areset) ovf_count <= '0;
    else if (push_vld && !push_ok && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 1'b1;
  end
`endif

  // Outputs read zero while empty so the reset values hold without clearing the array.
  assign m_axis_tvalid = ~fifo_empty;
  assign head          = fifo_empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign {m_axis_tdata, m_axis_tuser, m_axis_tlast} = head;

endmodule

// File: tb/tb_axis_rx_multilane.sv
// Directed bench for axis_rx_multilane: a packet-level queue model checks every output handshake,
// plus literal expectations for latency, framing, truncation, overflow and mid-packet reset.
`timescale 1ns/1ps
module tb_axis_rx_multilane;
  localparam int PL = 32, PPF = 4, DEPTH = 4;

  logic aclk = 1'b0, areset = 1'b1, enable = 1'b1;
  logic sclk = 1'b0, svalid = 1'b0;
  logic [0:0] sdata = 1'b0;
  logic [PL-1:0] tdata;
  logic tvalid, tready = 1'b1, tlast, tuser, overflow;
  logic sclk4 = 1'b0, svalid4 = 1'b0;
  logic [3:0] sdata4 = 4'h0;
  logic [PL-1:0] tdata4;
  logic tvalid4, tlast4, tuser4, overflow4;
`ifdef AXIS_RX_OVF_CNT_EN
  logic [15:0] ovf_count, ovf_count4;
`endif

  always #5 aclk = ~aclk;

  axis_rx_multilane #(.PACKET_LENGTH(PL), .NUM_LANES(1), .PKTS_PER_FRAME(PPF),
                      .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) u_dut (
    .aclk(aclk), .areset(areset), .enable(enable), .sclk(sclk), .sdata(sdata), .svalid(svalid),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .m_axis_tuser(tuser),
`ifdef AXIS_RX_OVF_CNT_EN
    .ovf_count(ovf_count),
`endif
    .overflow(overflow));

  axis_rx_multilane #(.PACKET_LENGTH(PL), .NUM_LANES(4), .PKTS_PER_FRAME(PPF),
                      .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) u_dut4 (
    .aclk(aclk), .areset(areset), .enable(enable), .sclk(sclk4), .sdata(sdata4), .svalid(svalid4),
    .m_axis_tdata(tdata4), .m_axis_tvalid(tvalid4), .m_axis_tready(1'b1),
    .m_axis_tlast(tlast4), .m_axis_tuser(tuser4),
`ifdef AXIS_RX_OVF_CNT_EN
    .ovf_count(ovf_count4),
`endif
    .overflow(overflow4));

  typedef struct packed {logic [PL-1:0] data; logic user; logic last;} word_t;

  word_t exp_q[$];
  word_t hs_q[$];
  int    m_frame = 0, m_drops = 0;
  bit    m_ovf = 1'b0;
  int    checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Packet-level model: every completed or truncated packet is one frame slot; it is queued
  // if fewer than DEPTH words are waiting, otherwise it is counted as dropped.
  task automatic model_push(input logic [PL-1:0] d, input bit u);
    word_t w;
    w.data = d;
    w.user = u;
    w.last = (m_frame == PPF - 1);
    m_frame = (m_frame + 1) % PPF;
    if (exp_q.size() < DEPTH) exp_q.push_back(w);
    else begin
      m_drops++;
      m_ovf = 1'b1;
    end
  endtask

  task automatic send_beat(input logic b, input logic v, input bit lat);
    @(negedge aclk);
    sdata = b; svalid = v; sclk = 1'b1;
    repeat (3) @(negedge aclk);
    sclk = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      if (lat && i == 2) check("latency_not_yet_valid", tvalid, 0);
      if (lat && i == 3) check("latency_valid", tvalid, 1);
    end
  endtask

  task automatic send_pkt(input logic [PL-1:0] val, input int nbits, input bit short_pkt, input bit lat);
    logic [PL-1:0] mask;
    mask = (nbits >= PL) ? '1 : ((PL'(1) << nbits) - 1);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (i == 0 && !short_pkt) model_push(val & mask, 1'b0);
      send_beat(val[i], 1'b1, lat && i == 0);
    end
    if (short_pkt) begin
      model_push(val & mask, 1'b1);
      send_beat(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b1; sclk = 1'b0; svalid = 1'b0; sdata = 1'b0;
    sclk4 = 1'b0; svalid4 = 1'b0; sdata4 = 4'h0;
    repeat (3) @(negedge aclk);
    exp_q.delete(); hs_q.delete();
    m_frame = 0; m_drops = 0; m_ovf = 1'b0;
    areset = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    repeat (5) @(negedge aclk);
    while ((exp_q.size() != 0 || tvalid) && n < 300) begin
      @(negedge aclk);
      n++;
    end
    check(name, (exp_q.size() == 0 && !tvalid), 1);
  endtask

  // Compare process: every handshake must match the model head; held words must not change.
  initial begin
    word_t cur, e, prev_w;
    bit prev_hold;
    prev_hold = 1'b0;
    prev_w = '0;
    forever begin
      @(negedge aclk); #1;
      if (areset) prev_hold = 1'b0;
      else begin
        cur = {tdata, tuser, tlast};
        if (prev_hold) begin
          check("hold_valid", tvalid, 1);
          check("hold_word", cur, prev_w);
        end
        if (tvalid && tready) begin
          hs_q.push_back(cur);
          check("beat_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("beat_data", cur.data, e.data);
            check("beat_user", cur.user, e.user);
            check("beat_last", cur.last, e.last);
          end
        end
        prev_hold = tvalid && !tready;
        prev_w = cur;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] lasts;
    do_reset();
    #1;
    check("reset_tvalid", tvalid, 0);
    check("reset_tdata", tdata, 0);
    check("reset_tlast", tlast, 0);
    check("reset_tuser", tuser, 0);
    check("reset_overflow", overflow, 0);
    check("reset_tvalid4", tvalid4, 0);
`ifdef AXIS_RX_OVF_CNT_EN
    check("reset_ovf_count", ovf_count, 0);
`endif

    // Single lane, one packet, latency measured from the last falling sclk.
    send_pkt(32'hDEADBEEF, 32, 1'b0, 1'b1);
    wait_drain("t1_drain");
    check("t1_count", hs_q.size(), 1);
    if (hs_q.size() == 1) begin
      check("t1_data", hs_q[0].data, 32'hDEADBEEF);
      check("t1_user", hs_q[0].user, 0);
      check("t1_last", hs_q[0].last, 0);
    end

    // Four lanes, nibbles 1..8.
    for (int n = 1; n <= 8; n++) begin
      @(negedge aclk);
      sdata4 = 4'(n); svalid4 = 1'b1; sclk4 = 1'b1;
      repeat (3) @(negedge aclk);
      sclk4 = 1'b0;
      repeat (4) @(negedge aclk);
    end
    svalid4 = 1'b0;
    check("lane4_valid", tvalid4, 1);
    check("lane4_data", tdata4, 32'h12345678);
    check("lane4_user", tuser4, 0);
    check("lane4_last", tlast4, 0);

    // Framing: tlast only on the fourth packet of a frame.
    do_reset();
    send_pkt(32'hA0000001, 32, 1'b0, 1'b0);
    send_pkt(32'hB0000002, 32, 1'b0, 1'b0);
    send_pkt(32'hC0000003, 32, 1'b0, 1'b0);
    send_pkt(32'hD0000004, 32, 1'b0, 1'b0);
    send_pkt(32'hE0000005, 32, 1'b0, 1'b0);
    wait_drain("t3_drain");
    check("t3_count", hs_q.size(), 5);
    if (hs_q.size() == 5) begin
      for (int k = 0; k < 5; k++) lasts[k] = hs_q[k].last;
      check("t3_tlast_pattern", lasts, 5'b01000);
      check("t3_d_data", hs_q[3].data, 32'hD0000004);
    end

    // Truncated packet after 12 bits, then two full packets; the frame slot still advances.
    hs_q.delete();
    send_pkt(32'h00000ABC, 12, 1'b1, 1'b0);
    send_pkt(32'h0F0F1234, 32, 1'b0, 1'b0);
    send_pkt(32'h13579BDF, 32, 1'b0, 1'b0);
    wait_drain("t4_drain");
    check("t4_count", hs_q.size(), 3);
    if (hs_q.size() == 3) begin
      check("t4_short_data", hs_q[0].data, 32'h00000ABC);
      check("t4_short_user", hs_q[0].user, 1);
      check("t4_short_last", hs_q[0].last, 0);
      check("t4_third_last", hs_q[2].last, 1);
    end

    // Back-pressure: six packets into a 4-deep FIFO, two dropped.
    do_reset();
    tready = 1'b0;
    for (int k = 0; k < 6; k++) send_pkt(32'h600D0000 + PL'(k), 32, 1'b0, 1'b0);
    repeat (6) @(negedge aclk);
    check("t5_model_queued", exp_q.size(), 4);
    check("t5_overflow", overflow, 1);
    check("t5_overflow_model", overflow, m_ovf);
`ifdef AXIS_RX_OVF_CNT_EN
    check("t5_ovf_count", ovf_count, 2);
    check("t5_ovf_count_model", ovf_count, m_drops);
`endif
    tready = 1'b1;
    wait_drain("t5_drain");
    check("t5_beats", hs_q.size(), 4);
    if (hs_q.size() == 4) begin
      check("t5_first", hs_q[0].data, 32'h600D0000);
      check("t5_fourth", hs_q[3].data, 32'h600D0003);
    end

    // Reset mid-packet after 10 bits, then a clean packet restarting the frame.
    for (int k = 0; k < 10; k++) send_beat(k[0], 1'b1, 1'b0);
    do_reset();
    #1;
    check("t6_overflow_cleared", overflow, 0);
`ifdef AXIS_RX_OVF_CNT_EN
    check("t6_ovf_count_cleared", ovf_count, 0);
`endif
    send_pkt(32'h5A5A5A5A, 32, 1'b0, 1'b0);
    send_pkt(32'h00000001, 1, 1'b1, 1'b0);
    send_pkt(32'h00000000, 1, 1'b1, 1'b0);
    send_pkt(32'h00000001, 1, 1'b1, 1'b0);
    wait_drain("t6_drain");
    check("t6_count", hs_q.size(), 4);
    if (hs_q.size() == 4) begin
      check("t6_data", hs_q[0].data, 32'h5A5A5A5A);
      check("t6_first_last", hs_q[0].last, 0);
      check("t6_fourth_last", hs_q[3].last, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis_rx_multilane.md
# axis_rx_multilane

Parametrised, multi-lane successor to the single-lane serial receiver. It oversamples a source-synchronous serial link (sclk, sdata lanes, svalid) from the ASIC entirely in the aclk domain and assembles packets of PACKET_LENGTH bits. Completed packets are queued in a first-word-fall-through FIFO and presented on an AXI4-Stream master port with full tready back-pressure, tlast framing and a short-packet flag. It sits between the ASIC pads and the DMA/AXI-Stream FIFO.

## Interface
- PACKET_LENGTH, 32: bits per packet; must be a multiple of NUM_LANES.
- NUM_LANES, 1: sdata lanes shifted per sclk edge (1, 2, 4 or 8).
- PKTS_PER_FRAME, 4: packets per tlast frame (≥1).
- FIFO_DEPTH, 4: output FIFO entries; power of 2, ≥2.
- SYNC_STAGES, 2: synchroniser flops on sclk/sdata/svalid (≥2).
- aclk  in  1  sole clock, rising edge.
- areset  in  1  synchronous, active-high reset.
- enable  in  1  receive enable.
- sclk  in  1  serial clock from ASIC, asynchronous to aclk.
- sdata  in  NUM_LANES  serial data; lane NUM_LANES-1 is most significant within a beat.
- svalid  in  1  packet-active qualifier.
- m_axis_tdata  out  PACKET_LENGTH  packet word.
- m_axis_tvalid  out  1  word valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tlast  out  1  last packet of frame.
- m_axis_tuser  out  1  1 = short (truncated) packet.
- overflow  out  1  sticky: a packet was dropped because the FIFO was full.
- ovf_count  out  16  dropped-packet count (present only with AXIS_RX_OVF_CNT_EN).

## Operation
- One clock, one synchronous active-high reset. sclk, sdata and svalid each pass through SYNC_STAGES flops. A sample event is sync'd sclk previous=1, current=0, with sdata/svalid taken from the same final stage. aclk must be ≥4× sclk.
- BEATS = PACKET_LENGTH/NUM_LANES. The assembler has two states, IDLE and SHIFT.
- IDLE, sample event with svalid=1: shift register = sdata (zero-extended), beat count = 1, enter SHIFT. If BEATS=1, push at once and stay in IDLE.
- SHIFT, sample event with svalid=1: shift register = {shift_reg, sdata} (MSB-first), increment beat count. When the count reaches BEATS, push the full word with tuser=0, clear the count and enter IDLE.
- SHIFT, sample event with svalid=0: push the partial word right-aligned with zero upper bits and tuser=1, then enter IDLE. The svalid level between sample events is ignored.
- Frame counter 0..PKTS_PER_FRAME-1 advances on every push attempt, full or short, accepted or dropped. The pushed entry has tlast=1 when the counter equals PKTS_PER_FRAME-1; the counter then wraps to 0.
- FIFO entry = {tdata, tuser, tlast}. A push is accepted if the FIFO is not full, or if a pop happens in the same cycle. Otherwise the word is dropped, overflow is set and ovf_count increments.
- Pop on m_axis_tvalid && m_axis_tready. m_axis_tvalid = FIFO not empty. While tvalid && !tready, tdata/tlast/tuser hold stable.
- enable=0: the assembler is forced to IDLE and any partial word is discarded without a push. The frame counter holds. The FIFO keeps draining normally. Synchronisers keep running.
- areset: assembler IDLE, beat count 0, shift register 0, frame counter 0, FIFO empty, synchronisers 0, overflow 0, ovf_count 0. A packet in progress is lost.

## Timing
- Reset values: m_axis_tvalid 0, m_axis_tdata 0, m_axis_tlast 0, m_axis_tuser 0, overflow 0, ovf_count 0.
- If the final sclk-low is first captured by sync stage 1 at aclk edge 0, the push occurs at edge SYNC_STAGES and m_axis_tvalid is high after edge SYNC_STAGES+1 (empty FIFO, ready sink).
- Throughput: one pop per aclk. A full-speed link never overflows while tready is held high.
- Simultaneous push and pop on a full FIFO: both occur, count unchanged, no overflow.
- Simultaneous push and pop on an empty FIFO: not possible. The pushed word appears the next cycle.
- overflow clears only on areset. ovf_count saturates at 16'hFFFF.

## Configuration
- AXIS_RX_OVF_CNT_EN defined: the ovf_count port and a 16-bit saturating drop counter exist.
- AXIS_RX_OVF_CNT_EN undefined: the ovf_count port and counter are absent. The overflow flag is always present.

## Test plan
- NUM_LANES=1, tready=1, send 32 bits 0xDEADBEEF MSB-first, svalid high for 32 edges -> one beat tdata=0xDEADBEEF, tuser=0, tlast=0, tvalid at the stated latency.
- NUM_LANES=4, send 8 nibbles 1,2,…,8 -> tdata=0x12345678.
- Four back-to-back packets A,B,C,D with PKTS_PER_FRAME=4 -> tlast=1 only on D; a fifth packet E has tlast=0.
- svalid drops after 12 bits 0xABC -> tdata=0x00000ABC, tuser=1; the frame counter advances.
- tready=0 with FIFO_DEPTH=4, send 6 packets -> first 4 are retained in order, overflow=1, ovf_count=2. Release tready -> exactly 4 beats.
- areset mid-packet (bit 10), then a clean packet 0x5A5A5A5A -> only 0x5A5A5A5A is output and the frame counter restarts at 0.
